pwm_capture: RTL

PWM input decoder: samples an external pulse-width-modulated signal, measures the period and high time of each cycle in system clocks, and derives an 8-bit duty value on the same 0–255 scale the LED PWM generators use. It sits next to the PWM output blocks on the I/O side. It is used to read back fan tachometers and servo or PWM sensors, and to loop-check our own PWM outputs.

---
 rtl/pwm_capture_if.sv | 27 ++
 rtl/pwm_capture.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture_if.sv
// Result bundle of the PWM input decoder: measured counts, derived duty,
// update strobe and stuck-input flag.
interface pwm_capture_if #(
  parameter int CNT_WIDTH = 16
);
  logic [CNT_WIDTH-1:0] o_Period_Count;
  logic [CNT_WIDTH-1:0] o_High_Count;
  logic [7:0]           o_Duty;
  logic                 o_Valid;
  logic                 o_Stuck;

  modport master (
    output o_Period_Count,
    output o_High_Count,
    output o_Duty,
    output o_Valid,
    output o_Stuck
  );

  modport slave (
    input o_Period_Count,
    input o_High_Count,
    input o_Duty,
    input o_Valid,
    input o_Stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM input decoder: measures period and high time of an asynchronous PWM
// input in system clocks and derives an 8-bit duty by restoring division.
module pwm_capture #(
  parameter int          CNT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_PWM,
  pwm_capture_if.master res
);

  typedef enum logic [1:0] {
    ARMING,
    MEASURE,
    DIVIDE
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TimeoutC = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] OneC     = CNT_WIDTH'(1);

  logic sync1_q, sync2_q, hist_q;
  logic rise, fall;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] high_q, high_d;
  logic [CNT_WIDTH-1:0] per_op_q, per_op_d;
  logic [CNT_WIDTH-1:0] high_op_q, high_op_d;
  logic [CNT_WIDTH:0]   rem_q, rem_d;
  logic [7:0]           quo_q, quo_d;
  logic [3:0]           step_q, step_d;
  logic [CNT_WIDTH-1:0] per_out_q, per_out_d;
  logic [CNT_WIDTH-1:0] high_out_q, high_out_d;
  logic [7:0]           duty_q, duty_d;
  logic                 valid_q, valid_d;
  logic                 stuck_q, stuck_d;

  logic [CNT_WIDTH-1:0] count_inc;
  logic                 timeout;
  logic [CNT_WIDTH:0]   rem_sh;
  logic                 rem_ge;

  assign rise = sync2_q & ~hist_q;
  assign fall = ~sync2_q & hist_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= i_PWM;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ARMING;
      count_q    <= '0;
      high_q     <= '0;
      per_op_q   <= '0;
      high_op_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      step_q     <= '0;
      per_out_q  <= '0;
      high_out_q <= '0;
      duty_q     <= '0;
      valid_q    <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      high_q     <= high_d;
      per_op_q   <= per_op_d;
      high_op_q  <= high_op_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      step_q     <= step_d;
      per_out_q  <= per_out_d;
      high_out_q <= high_out_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    high_d     = high_q;
    per_op_d   = per_op_q;
    high_op_d  = high_op_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    step_d     = step_q;
    per_out_d  = per_out_q;
    high_out_d = high_out_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    stuck_d    = stuck_q;

    timeout   = (count_q == TimeoutC);
    count_inc = timeout ? count_q : count_q + OneC;
    rem_sh    = rem_q << 1;
    rem_ge    = (rem_sh >= {1'b0, per_op_q});

    case (state_q)
      ARMING: begin
        count_d = count_inc;
        if (rise) begin
          count_d = OneC;
          state_d = MEASURE;
        end else if (timeout && !stuck_q) begin
          // Stuck flag gates re-reporting so an idle input yields one pulse only.
          per_out_d  = '0;
          high_out_d = '0;
          duty_d     = sync2_q ? 8'hFF : 8'h00;
          valid_d    = 1'b1;
          stuck_d    = 1'b1;
          count_d    = '0;
        end
      end

      MEASURE: begin
        count_d = count_inc;
        if (timeout) begin
          state_d = ARMING;
          count_d = '0;
          if (!stuck_q) begin
            per_out_d  = '0;
            high_out_d = '0;
            duty_d     = sync2_q ? 8'hFF : 8'h00;
            valid_d    = 1'b1;
            stuck_d    = 1'b1;
          end
        end else begin
          if (fall) begin
            high_d = count_q;
          end
          if (rise) begin
            per_op_d  = count_q;
            high_op_d = high_q;
            rem_d     = {1'b0, high_q};
            quo_d     = '0;
            step_d    = '0;
            count_d   = OneC;
            state_d   = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        // Edge tracking continues; a rise here only restarts the period count.
        count_d = count_inc;
        if (fall) begin
          high_d = count_q;
        end
        if (rise) begin
          count_d = OneC;
        end
        if (step_q != 4'd8) begin
          rem_d  = rem_ge ? (rem_sh - {1'b0, per_op_q}) : rem_sh;
          quo_d  = {quo_q[6:0], rem_ge};
          step_d = step_q + 4'd1;
        end else begin
          per_out_d  = per_op_q;
          high_out_d = high_op_q;
          duty_d     = quo_q;
          valid_d    = 1'b1;
          stuck_d    = 1'b0;
          state_d    = MEASURE;
        end
      end

      default: state_d = ARMING;
    endcase
  end

  assign res.o_Period_Count = per_out_q;
  assign res.o_High_Count   = high_out_q;
  assign res.o_Duty         = duty_q;
  assign res.o_Valid        = valid_q;
  assign res.o_Stuck        = stuck_q;

endmodule
